// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  localparam int MIN_DIV = 2;
  localparam int MAXW    = 64;
  localparam int HW      = MAXW + 1;

  // ceil(D/2), computed one bit wider so D = all-ones cannot overflow
  function automatic logic [MAXW:0] half_hi(input logic [MAXW-1:0] d);
    return ({1'b0, d} + HW'(1)) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and phase compare; O_CLK/O_TICK are registered from the next count.
module clk_div_core #(
  parameter int W = 32
) (
  input  logic         I_CLK,
  input  logic         Rst,
  input  logic         en,
  input  logic         restart,
  input  logic [W-1:0] div,
  output logic         O_CLK,
  output logic         O_TICK,
  output logic         boundary
);
  import clk_div_pkg::*;

  logic [W-1:0]  cnt;
  logic [W-1:0]  cnt_nxt;
  logic          wrap;
  logic [MAXW:0] half;

  assign half     = half_hi(MAXW'(div));
  assign boundary = (cnt == div - W'(1));
  assign wrap     = restart | boundary;
  assign cnt_nxt  = wrap ? '0 : cnt + W'(1);

  always_ff @(posedge I_CLK) begin
    if (!Rst || !en) begin
      cnt    <= '0;
      O_CLK  <= 1'b0;
      O_TICK <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      O_CLK  <= (HW'(cnt_nxt) < half);
      O_TICK <= wrap;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Start/stop sequencing and glitch-free ratio update for the divided clock.
module clk_div_ctrl #(
  parameter int W       = 32,
  parameter int DEF_DIV = 20
) (
  input  logic         I_CLK,
  input  logic         Rst,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  input  logic         start,
  input  logic         stop,
  output logic         O_CLK,
  output logic         O_TICK,
  output logic         busy
);
  import clk_div_pkg::*;

  state_t       state, state_nxt;
  logic [W-1:0] active, shadow;
  logic         pending;
  logic         en, restart, boundary;
  logic         xfer, bad;

  assign cfg_ready = !pending;
  assign xfer      = cfg_valid & cfg_ready;
  assign bad       = (cfg_div < W'(MIN_DIV));
  assign busy      = (state != IDLE);
  assign en        = (state_nxt != IDLE);

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    case (state)
      IDLE: if (start && !stop) begin
        state_nxt = RUN;
        restart   = 1'b1;
      end
      RUN: if (stop) state_nxt = RUN == RUN ? STOPPING : RUN;
      STOPPING: begin
        if (start)         state_nxt = RUN;
        else if (boundary) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!Rst) begin
      state   <= IDLE;
      active  <= W'(DEF_DIV);
      shadow  <= '0;
      pending <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= xfer & bad;
      if (xfer && !bad) begin
        // no period in flight (or the last one is ending): take it immediately
        if (state == IDLE || state_nxt == IDLE) begin
          active <= cfg_div;
        end else begin
          shadow  <= cfg_div;
          pending <= 1'b1;
        end
      end else if (pending && boundary) begin
        active  <= shadow;
        pending <= 1'b0;
      end
    end
  end

  clk_div_core #(.W(W)) u_core (
    .I_CLK    (I_CLK),
    .Rst      (Rst),
    .en       (en),
    .restart  (restart),
    .div      (active),
    .O_CLK    (O_CLK),
    .O_TICK   (O_TICK),
    .boundary (boundary)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scenario bench for clk_div_ctrl; expected {O_CLK,O_TICK,busy,cfg_ready,cfg_err} queued per cycle.
module tb_clk_div_ctrl;

  logic        I_CLK;
  logic        Rst;
  logic        cfg_valid;
  logic [31:0] cfg_div;
  logic        cfg_ready;
  logic        cfg_err;
  logic        start;
  logic        stop;
  logic        O_CLK;
  logic        O_TICK;
  logic        busy;

  logic [4:0]  obs;
  logic [4:0]  sb[$];
  int          vecs;
  int          fails;

  assign obs = {O_CLK, O_TICK, busy, cfg_ready, cfg_err};

  clk_div_ctrl #(.W(32), .DEF_DIV(20)) dut (
    .I_CLK     (I_CLK),
    .Rst       (Rst),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .start     (start),
    .stop      (stop),
    .O_CLK     (O_CLK),
    .O_TICK    (O_TICK),
    .busy      (busy)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  localparam logic [4:0] IDLE_V = 5'b00010;
  localparam logic [4:0] ERR_V  = 5'b00011;

  // running-state expectation for phase p of a period of d cycles
  function automatic logic [4:0] run_exp(int p, int d, logic rdy);
    logic hi, tk;
    hi = (p < (d + 1) / 2);
    tk = (p == 0);
    return {hi, tk, 1'b1, rdy, 1'b0};
  endfunction

  task automatic do_reset();
    {start, stop, cfg_valid} = 3'b000;
    cfg_div = 32'd0;
    Rst = 1'b0;
    repeat (2) @(posedge I_CLK);
    #1 Rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] ex;
    {start, stop, cfg_valid} = 3'b000;
    cfg_div = 32'd0;
    for (int i = 0; i < 3; i++) begin
      Rst = 1'b0;
      sb.push_back(IDLE_V);
      @(posedge I_CLK); #1;
      ex = sb.pop_front(); vecs++;
      if (obs !== ex) begin fails++; $display("FAIL reset cyc %0d: got %b want %b", i, obs, ex); end
    end
    Rst = 1'b1;
  endtask

  task automatic test_default_start();
    logic [4:0] ex;
    do_reset();
    for (int i = 0; i < 45; i++) begin
      start = (i == 4);
      sb.push_back(i < 4 ? IDLE_V : run_exp((i - 4) % 20, 20, 1'b1));
      @(posedge I_CLK); #1;
      ex = sb.pop_front(); vecs++;
      if (obs !== ex) begin fails++; $display("FAIL default_start cyc %0d: got %b want %b", i, obs, ex); end
    end
  endtask

  task automatic test_cfg_idle();
    logic [4:0] ex;
    do_reset();
    for (int i = 0; i < 52; i++) begin
      cfg_valid = (i == 0);
      cfg_div   = 32'd5;
      start     = (i == 1);
      sb.push_back(i == 0 ? IDLE_V : run_exp((i - 1) % 5, 5, 1'b1));
      @(posedge I_CLK); #1;
      ex = sb.pop_front(); vecs++;
      if (obs !== ex) begin fails++; $display("FAIL cfg_idle cyc %0d: got %b want %b", i, obs, ex); end
    end
  endtask

  task automatic test_min_div();
    logic [4:0] ex;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cfg_valid = (i == 0);
      cfg_div   = 32'd2;
      start     = (i == 0);
      sb.push_back(run_exp(i % 2, 2, 1'b1));
      @(posedge I_CLK); #1;
      ex = sb.pop_front(); vecs++;
      if (obs !== ex) begin fails++; $display("FAIL min_div cyc %0d: got %b want %b", i, obs, ex); end
    end
  endtask

  // second offer is held off while the first one is pending
  task automatic test_cfg_run();
    logic [4:0] ex;
    do_reset();
    for (int i = 0; i < 41; i++) begin
      start     = (i == 0);
      cfg_valid = (i >= 5 && i <= 19);
      cfg_div   = (i == 5) ? 32'd4 : 32'd7;
      sb.push_back(i < 20 ? run_exp(i, 20, i < 5) : run_exp((i - 20) % 4, 4, 1'b1));
      @(posedge I_CLK); #1;
      ex = sb.pop_front(); vecs++;
      if (obs !== ex) begin fails++; $display("FAIL cfg_run cyc %0d: got %b want %b", i, obs, ex); end
    end
  endtask

  task automatic test_cfg_err();
    logic [4:0] ex, e;
    do_reset();
    for (int i = 0; i < 31; i++) begin
      cfg_valid = (i == 0 || i == 2 || i == 7);
      cfg_div   = (i == 2) ? 32'd0 : 32'd1;
      start     = (i == 4);
      if (i < 4) e = (i == 0 || i == 2) ? ERR_V : IDLE_V;
      else begin
        e = run_exp((i - 4) % 20, 20, 1'b1);
        if (i == 7) e[0] = 1'b1;
      end
      sb.push_back(e);
      @(posedge I_CLK); #1;
      ex = sb.pop_front(); vecs++;
      if (obs !== ex) begin fails++; $display("FAIL cfg_err cyc %0d: got %b want %b", i, obs, ex); end
    end
  endtask

  task automatic test_stop();
    logic [4:0] ex, e;
    do_reset();
    for (int i = 0; i < 46; i++) begin
      cfg_valid = (i == 0);
      cfg_div   = 32'd8;
      start     = (i == 1 || i == 20 || i == 27);
      stop      = (i == 13 || i == 24);
      if (i == 0 || (i >= 17 && i <= 19)) e = IDLE_V;
      else if (i < 17)                    e = run_exp((i - 1) % 8, 8, 1'b1);
      else                                e = run_exp((i - 20) % 8, 8, 1'b1);
      sb.push_back(e);
      @(posedge I_CLK); #1;
      ex = sb.pop_front(); vecs++;
      if (obs !== ex) begin fails++; $display("FAIL stop cyc %0d: got %b want %b", i, obs, ex); end
    end
    stop = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [4:0] ex, e;
    do_reset();
    for (int i = 0; i < 31; i++) begin
      Rst       = (i != 3);
      cfg_valid = (i == 0 || i == 2);
      cfg_div   = (i == 0) ? 32'd6 : 32'd4;
      start     = (i == 1 || i == 5);
      case (i)
        0, 3, 4: e = IDLE_V;
        1:       e = run_exp(0, 6, 1'b1);
        2:       e = run_exp(1, 6, 1'b0);
        default: e = run_exp((i - 5) % 20, 20, 1'b1);
      endcase
      sb.push_back(e);
      @(posedge I_CLK); #1;
      ex = sb.pop_front(); vecs++;
      if (obs !== ex) begin fails++; $display("FAIL reset_mid cyc %0d: got %b want %b", i, obs, ex); end
    end
  endtask

  initial begin
    vecs  = 0;
    fails = 0;
    Rst   = 1'b0;
    test_reset();
    test_default_start();
    test_cfg_idle();
    test_min_div();
    test_cfg_run();
    test_cfg_err();
    test_stop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
